// File: rtl/gfx_mem_arbiter.sv
// rtl/gfx_mem_arbiter.sv - three-requester round-robin arbiter onto a single memory master bus
// One transaction in flight at a time; ack, error, timeout or owner abort all return to IDLE.
module gfx_mem_arbiter #(
    parameter int MDW     = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       req_rd_i,
    input  logic [2:0]       req_wr_i,
    input  logic [95:0]      req_addr_i,
    input  logic [95:0]      req_sel_i,
    input  logic [3*MDW-1:0] req_dat_i,
    output logic [2:0]       req_ack_o,
    output logic [2:0]       req_err_o,
    output logic [MDW-1:0]   req_dat_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [31:0]      m_adr_o,
    output logic [31:0]      m_sel_o,
    output logic [MDW-1:0]   m_dat_o,
    input  logic [MDW-1:0]   m_dat_i,
    input  logic             m_ack_i,
    input  logic             m_err_i,
    output logic [2:0]       grant_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [15:0]      timer_q, timer_d;
    logic             m_we_q, m_we_d;
    logic [31:0]      m_adr_q, m_adr_d;
    logic [31:0]      m_sel_q, m_sel_d;
    logic [MDW-1:0]   m_dat_q, m_dat_d;

    logic [2:0]       req_any;
    logic [1:0]       pick;
    logic             is_busy;
    logic             owner_req;
    logic             timeout_hit;

    // Scan from the farthest offset back to the nearest so the first requester
    // after last_grant is the one left in pick.
    always_comb begin
        pick = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            int idx;
            idx = (int'(last_grant_q) + 1 + k) % 3;
            if (req_any[idx]) begin
                pick = 2'(idx);
            end
        end
    end

    always_comb begin
        req_any     = req_rd_i | req_wr_i;
        is_busy     = (state_q == BUSY);
        owner_req   = |(req_any & grant_q);
        timeout_hit = (timer_q == 16'(TIMEOUT));

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        m_we_d       = m_we_q;
        m_adr_d      = m_adr_q;
        m_sel_d      = m_sel_q;
        m_dat_d      = m_dat_q;

        req_ack_o = (is_busy && m_ack_i) ? grant_q : 3'b000;
        // An owner that has already dropped its request is aborting, not failing.
        req_err_o = (is_busy && !m_ack_i && owner_req && (m_err_i || timeout_hit))
                    ? grant_q : 3'b000;

        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    state_d      = BUSY;
                    grant_d      = 3'b001 << pick;
                    last_grant_d = pick;
                    timer_d      = 16'd0;
                    m_we_d       = req_wr_i[pick];
                    m_adr_d      = req_addr_i[32*pick +: 32];
                    m_sel_d      = req_sel_i[32*pick +: 32];
                    m_dat_d      = req_dat_i[MDW*pick +: MDW];
                end
            end
            BUSY: begin
                if (m_ack_i || m_err_i || timeout_hit || !owner_req) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                end else if (!timeout_hit) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            last_grant_q <= 2'd2;
            timer_q      <= 16'd0;
            m_we_q       <= 1'b0;
            m_adr_q      <= 32'd0;
            m_sel_q      <= 32'd0;
            m_dat_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            m_we_q       <= m_we_d;
            m_adr_q      <= m_adr_d;
            m_sel_q      <= m_sel_d;
            m_dat_q      <= m_dat_d;
        end
    end

    assign m_cyc_o   = is_busy;
    assign m_stb_o   = is_busy;
    assign busy_o    = is_busy;
    assign grant_o   = grant_q;
    assign m_we_o    = m_we_q;
    assign m_adr_o   = m_adr_q;
    assign m_sel_o   = m_sel_q;
    assign m_dat_o   = m_dat_q;
    assign req_dat_o = m_dat_i;

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb/tb_gfx_mem_arbiter.sv - directed self-checking bench for gfx_mem_arbiter
module tb_gfx_mem_arbiter;

    localparam int MDW = 64;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [2:0]       req_rd_i, req_wr_i;
    logic [95:0]      req_addr_i, req_sel_i;
    logic [3*MDW-1:0] req_dat_i;
    logic [2:0]       req_ack_o, req_err_o, grant_o;
    logic [MDW-1:0]   req_dat_o, m_dat_o, m_dat_i;
    logic             m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_err_i, busy_o;
    logic [31:0]      m_adr_o, m_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    gfx_mem_arbiter #(.MDW(MDW), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_rd_i(req_rd_i), .req_wr_i(req_wr_i),
        .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
        .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1ns later.
    task automatic fall();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        rst_i      = 1'b0;
        req_rd_i   = 3'b000;
        req_wr_i   = 3'b000;
        req_addr_i = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        req_sel_i  = {32'h0000_00F0, 32'h0000_0F0F, 32'hFFFF_FFFF};
        req_dat_i  = {64'hCCCC_0000_0000_0002, 64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        m_dat_i    = '0;
        m_ack_i    = 1'b0;
        m_err_i    = 1'b0;

        fall();
        check("rst_grant", 64'(grant_o), 64'h0);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("rst_cyc", 64'({m_cyc_o, m_stb_o, m_we_o}), 64'h0);
        check("rst_adr", 64'({m_adr_o, m_sel_o}), 64'h0);
        check("rst_dat", 64'(m_dat_o), 64'h0);
        fall();
        rst_i = 1'b1;

        // Single write from requester 0, slave acks on the fourth BUSY cycle.
        fall();
        req_wr_i = 3'b001;
        #1;
        check("wr_not_yet", 64'(m_cyc_o), 64'h0);
        fall();
        check("wr_cyc", 64'({m_cyc_o, m_stb_o}), 64'h3);
        check("wr_grant", 64'(grant_o), 64'h1);
        check("wr_we", 64'(m_we_o), 64'h1);
        check("wr_adr", 64'(m_adr_o), 64'h1000);
        check("wr_sel", 64'(m_sel_o), 64'hFFFF_FFFF);
        check("wr_dat", 64'(m_dat_o), 64'hAAAA_0000_0000_0000);
        fall();
        fall();
        check("wr_no_early_ack", 64'(req_ack_o), 64'h0);
        fall();
        m_ack_i = 1'b1;
        #1;
        check("wr_ack", 64'(req_ack_o), 64'h1);
        check("wr_ack_noerr", 64'(req_err_o), 64'h0);
        fall();
        m_ack_i  = 1'b0;
        req_wr_i = 3'b000;
        #1;
        check("wr_cyc_drop", 64'(m_cyc_o), 64'h0);
        check("wr_ack_once", 64'(req_ack_o), 64'h0);
        fall();
        check("wr_no_regrant", 64'(busy_o), 64'h0);

        // Fairness from reset: three readers held -> 0,1,2,0,1,2 with IDLE gaps.
        rst_i = 1'b0;
        fall();
        rst_i    = 1'b1;
        req_rd_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            fall();
            check($sformatf("rr_grant%0d", i), 64'(grant_o), 64'(3'b001 << (i % 3)));
            check($sformatf("rr_we%0d", i), 64'(m_we_o), 64'h0);
            m_ack_i = 1'b1;
            #1;
            check($sformatf("rr_ack%0d", i), 64'(req_ack_o), 64'(3'b001 << (i % 3)));
            fall();
            m_ack_i = 1'b0;
            if (i == 5) req_rd_i = 3'b000;
            #1;
            check($sformatf("rr_idle%0d", i), 64'({busy_o, grant_o}), 64'h0);
        end

        // Slave response in IDLE is ignored.
        m_ack_i = 1'b1;
        m_err_i = 1'b1;
        #1;
        check("idle_resp", 64'({req_ack_o, req_err_o}), 64'h0);
        m_ack_i = 1'b0;
        m_err_i = 1'b0;

        // Read by requester 2 with data returned alongside ack.
        req_rd_i = 3'b100;
        fall();
        check("rd2_grant", 64'(grant_o), 64'h4);
        check("rd2_adr", 64'({m_adr_o, m_sel_o}), {32'h3000, 32'h00F0});
        m_dat_i = 64'h1234_5678_DEAD_BEEF;
        m_ack_i = 1'b1;
        #1;
        check("rd2_dat", 64'(req_dat_o[31:0]), 64'hDEAD_BEEF);
        check("rd2_ack", 64'(req_ack_o), 64'h4);
        fall();
        m_ack_i  = 1'b0;
        req_rd_i = 3'b000;

        // Requester 1 with rd and wr both high; ack and err collide.
        fall();
        req_rd_i = 3'b010;
        req_wr_i = 3'b010;
        fall();
        check("rw1_we", 64'(m_we_o), 64'h1);
        check("rw1_adr", 64'(m_adr_o), 64'h2000);
        m_ack_i = 1'b1;
        m_err_i = 1'b1;
        #1;
        check("col_ack", 64'(req_ack_o), 64'h2);
        check("col_err", 64'(req_err_o), 64'h0);
        fall();
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        req_rd_i = 3'b000;
        req_wr_i = 3'b000;
        #1;
        check("col_exit", 64'(m_cyc_o), 64'h0);

        // Plain slave error for requester 0.
        fall();
        req_wr_i = 3'b001;
        fall();
        m_err_i = 1'b1;
        #1;
        check("err_pulse", 64'({req_ack_o, req_err_o}), 64'h1);
        fall();
        m_err_i  = 1'b0;
        req_wr_i = 3'b000;
        #1;
        check("err_exit", 64'(m_cyc_o), 64'h0);

        // Owner abort: requester 2 drops its read mid-BUSY; requester 0 is ignored meanwhile.
        fall();
        req_rd_i = 3'b100;
        fall();
        req_rd_i = 3'b101;
        fall();
        check("abort_hold", 64'(grant_o), 64'h4);
        req_rd_i = 3'b000;
        #1;
        check("abort_nopulse", 64'({req_ack_o, req_err_o}), 64'h0);
        fall();
        check("abort_exit", 64'({m_cyc_o, grant_o}), 64'h0);

        // Timeout with TIMEOUT=4: error on the fifth BUSY cycle.
        req_wr_i = 3'b001;
        for (int c = 1; c <= 5; c++) begin
            fall();
            check($sformatf("to_busy%0d", c), 64'(busy_o), 64'h1);
            check($sformatf("to_err%0d", c), 64'(req_err_o), (c == 5) ? 64'h1 : 64'h0);
        end
        fall();
        req_wr_i = 3'b000;
        #1;
        check("to_exit", 64'(m_cyc_o), 64'h0);

        // Asynchronous reset mid-transaction, then restart at requester 0.
        fall();
        req_rd_i = 3'b010;
        fall();
        check("rst_mid_pre", 64'(grant_o), 64'h2);
        rst_i   = 1'b0;
        m_ack_i = 1'b1;
        #1;
        check("rst_mid_cyc", 64'({m_cyc_o, m_stb_o, grant_o}), 64'h0);
        check("rst_mid_pulse", 64'({req_ack_o, req_err_o}), 64'h0);
        fall();
        m_ack_i  = 1'b0;
        rst_i    = 1'b1;
        req_rd_i = 3'b111;
        fall();
        check("rst_restart", 64'(grant_o), 64'h1);
        req_rd_i = 3'b000;
        fall();
        check("rst_final_idle", 64'(busy_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
